mole_spawner: RTL and testbench
===============================

Name: mole_spawner

Overview:
- Upstream stage of the whack handler. Decides which of the 16 holes shows a mole, when it appears, and how long it stays up.
- Drives the 16-bit one-hot mole vector that the whack handler compares against the hammer switches.
- Consumes the handler's whacked flag to retire a hit mole early.
- Emits single-cycle hit/miss/spawn events for the downstream scorer.

Parameters:
- UP_CYCLES, 50_000_000: clock cycles a mole stays up before it counts as missed (must be >= 2).
- GAP_CYCLES, 25_000_000: clock cycles with no mole between moles (must be >= 1).
- LFSR_SEED, 16'hACE1: LFSR reset value; a zero value is replaced by 16'h0001.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- enable_i  input  1  game running; low forces idle
- whacked_i  input  1  from whack handler; high = current mole struck
- mole_o  output  16  one-hot active mole, all zeros when no mole
- mole_idx_o  output  4  index of the current/last mole
- spawn_o  output  1  one-cycle pulse, first cycle a mole is up
- hit_o  output  1  one-cycle pulse, mole retired by whack
- miss_o  output  1  one-cycle pulse, mole retired by timeout

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: mole_o=0, mole_idx_o=0, spawn_o=0, hit_o=0, miss_o=0, state=IDLE, timer=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (mask 16'hB400). Advances every cycle in every state, including IDLE, so entropy comes from how long the player waits before starting.
- Timer: single down-counter, width $clog2(max(UP_CYCLES,GAP_CYCLES)+1).
- IDLE state:
  - mole_o=0.
  - When enable_i=1, load timer=GAP_CYCLES-1 and go to GAP.
- GAP state:
  - mole_o=0; timer decrements each cycle.
  - At timer==0: candidate = LFSR[3:0].
  - If candidate == mole_idx_o, use candidate+1 mod 16 instead, so the same hole never repeats back-to-back. This rule also applies to the first mole after reset, compared against idx 0.
  - Register mole_idx_o=candidate, mole_o=1<<candidate, spawn_o=1, timer=UP_CYCLES-1, go to UP.
  - GAP therefore lasts exactly GAP_CYCLES cycles.
- UP state:
  - mole_o holds for at most UP_CYCLES cycles; whacked_i is sampled every cycle.
  - whacked_i=1: next cycle mole_o=0, hit_o=1, timer=GAP_CYCLES-1, go to GAP.
  - Else if timer==0: next cycle mole_o=0, miss_o=1, timer=GAP_CYCLES-1, go to GAP.
  - Else: timer decrements.
  - whacked_i and timer==0 in the same cycle: the hit wins; miss_o stays 0.
  - whacked_i is ignored outside UP (a stale flag in GAP/IDLE has no effect).
- enable_i=0 in any state: next cycle go to IDLE, mole_o=0, all pulses 0, no hit/miss reported. mole_idx_o is retained.
- Pulses: at most one of spawn_o/hit_o/miss_o is high in any cycle, and each is high for exactly one cycle.
- Reset mid-mole: mole_o clears immediately (asynchronous). No miss is reported.

Decomposition:
- Shared package (whack-a-mole game package):
  - NUM_HOLES=16, HOLE_IDX_W=4.
  - LFSR tap mask constant.
  - State enum {IDLE, GAP, UP}, shared with the future scorer and display driver.
- One natural sub-module: mole_lfsr.
  - Inputs: clk_i, reset_i, seed parameter.
  - Output: 16-bit free-running state.
  - Reused later for difficulty jitter.
- Decoder and FSM stay in the top.

Test Plan (UP_CYCLES=8, GAP_CYCLES=4, LFSR_SEED=16'hACE1):
1. Reset high for 3 cycles, then low, enable_i=1, whacked_i=0 -> mole_o=0 for exactly 4 cycles after enable, then spawn_o pulses. mole_o is one-hot and equals 1<<mole_idx_o, and mole_idx_o matches the reference-model LFSR[3:0] (+1 if equal to 0).
2. No whack -> mole_o nonzero for exactly 8 cycles, then miss_o=1 for one cycle with mole_o=0. The next spawn comes 4 cycles later at a different index; repeat for 200 moles and check no back-to-back index repeat.
3. whacked_i=1 on the 3rd cycle of UP -> next cycle mole_o=0, hit_o=1, miss_o=0. The next spawn_o comes exactly 4 cycles after hit_o.
4. whacked_i=1 on the 8th (final) UP cycle -> hit_o=1, miss_o=0 (hit wins the collision).
5. Drop enable_i on the 5th UP cycle -> next cycle mole_o=0, no hit/miss pulse. Re-raise enable_i -> 4-cycle gap, then a new spawn.
6. Assert reset_i asynchronously mid-UP (between edges) -> mole_o=0 before the next edge. After release, the LFSR restarts from 16'hACE1, so the spawn index sequence is identical to scenario 1.

Source files
------------

// File: rtl/mole_pkg.sv
// Whack-a-mole game package: hole geometry, LFSR taps, game FSM states and
// the registered output bundle of the mole spawner.
package mole_pkg;

    localparam int unsigned NUM_HOLES  = 16;
    localparam int unsigned HOLE_IDX_W = 4;
    localparam int unsigned LFSR_W     = 16;

    // Galois taps for x^16 + x^14 + x^13 + x^11
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Game phase, shared with the scorer and display driver
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2
    } mole_state_e;

    // Registered spawner outputs, kept together so they share one flop bank
    typedef struct packed {
        logic [NUM_HOLES-1:0]  mole;
        logic [HOLE_IDX_W-1:0] idx;
        logic                  spawn;
        logic                  hit;
        logic                  miss;
    } mole_out_t;

    // One right-shifting Galois LFSR step
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    // Hole index to one-hot mole vector
    function automatic logic [NUM_HOLES-1:0] hole_onehot(input logic [HOLE_IDX_W-1:0] idx);
        logic [NUM_HOLES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR used as the game's entropy source.
// Ports:
//   clk_i    system clock
//   reset_i  asynchronous, active-high reset (loads the seed)
//   state_o  current LFSR state, advances every clock
module mole_lfsr
    import mole_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    output logic [LFSR_W-1:0] state_o
);

    // An all-zero seed would lock the LFSR, so substitute 1
    localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : LFSR_W'(SEED);

    logic [LFSR_W-1:0] state_q;

    // LFSR register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= SEED_NZ;
        end else begin
            state_q <= lfsr_step(state_q);
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: chooses which hole shows a mole, times the gap between moles
// and how long a mole stays up, and reports spawn/hit/miss events.
// Ports:
//   clk_i       system clock
//   reset_i     asynchronous, active-high reset
//   enable_i    game running; low forces idle
//   whacked_i   from whack handler; high = current mole struck
//   mole_o      one-hot active mole, zero when no mole is up
//   mole_idx_o  index of the current/last mole
//   spawn_o     one-cycle pulse on the first cycle a mole is up
//   hit_o       one-cycle pulse when a mole is retired by a whack
//   miss_o      one-cycle pulse when a mole is retired by timeout
module mole_spawner
    import mole_pkg::*;
#(
    parameter int unsigned UP_CYCLES  = 50_000_000,
    parameter int unsigned GAP_CYCLES = 25_000_000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic                  whacked_i,
    output logic [NUM_HOLES-1:0]  mole_o,
    output logic [HOLE_IDX_W-1:0] mole_idx_o,
    output logic                  spawn_o,
    output logic                  hit_o,
    output logic                  miss_o
);

    localparam int unsigned MAX_CYCLES = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
    localparam int unsigned TIMER_W    = $clog2(MAX_CYCLES + 1);

    localparam logic [TIMER_W-1:0] UP_LOAD  = TIMER_W'(UP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

    mole_state_e           state_q;
    mole_state_e           state_d;
    logic [TIMER_W-1:0]    timer_q;
    logic [TIMER_W-1:0]    timer_d;
    mole_out_t             out_q;
    mole_out_t             out_d;
    logic [LFSR_W-1:0]     lfsr;
    logic [HOLE_IDX_W-1:0] cand;
    logic                  unused_lfsr_bits;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .state_o (lfsr)
    );

    // Only the low nibble picks a hole; upper bits are kept for later jitter use
    assign unused_lfsr_bits = ^lfsr[LFSR_W-1:HOLE_IDX_W];

    // Next hole: bump by one when the LFSR would repeat the previous hole
    always_comb begin
        cand = lfsr[HOLE_IDX_W-1:0];
        if (cand == out_q.idx) begin
            cand = cand + HOLE_IDX_W'(1);
        end
    end

    // State, timer and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            out_q   <= out_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        out_d       = out_q;
        out_d.spawn = 1'b0;
        out_d.hit   = 1'b0;
        out_d.miss  = 1'b0;

        if (!enable_i) begin
            // Leaving the game drops any mole silently; the index is kept
            state_d    = IDLE;
            out_d.mole = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    out_d.mole = '0;
                    timer_d    = GAP_LOAD;
                    state_d    = GAP;
                end
                GAP: begin
                    out_d.mole = '0;
                    if (timer_q == '0) begin
                        out_d.idx   = cand;
                        out_d.mole  = hole_onehot(cand);
                        out_d.spawn = 1'b1;
                        timer_d     = UP_LOAD;
                        state_d     = UP;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                UP: begin
                    // A whack on the last up cycle still counts as a hit
                    if (whacked_i) begin
                        out_d.mole = '0;
                        out_d.hit  = 1'b1;
                        timer_d    = GAP_LOAD;
                        state_d    = GAP;
                    end else if (timer_q == '0) begin
                        out_d.mole = '0;
                        out_d.miss = 1'b1;
                        timer_d    = GAP_LOAD;
                        state_d    = GAP;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: begin
                    out_d.mole = '0;
                    state_d    = IDLE;
                end
            endcase
        end
    end

    assign mole_o     = out_q.mole;
    assign mole_idx_o = out_q.idx;
    assign spawn_o    = out_q.spawn;
    assign hit_o      = out_q.hit;
    assign miss_o     = out_q.miss;

endmodule

// File: tb/tb_mole_spawner.sv
// Scoreboard bench for mole_spawner with UP_CYCLES=8, GAP_CYCLES=4, seed ACE1.
// Edge k is the k-th rising clock edge after reset release (k starts at 0);
// the LFSR value sampled at edge k is the seed stepped k times.
module tb_mole_spawner;

    localparam int unsigned UP_N    = 8;
    localparam int unsigned GAP_N   = 4;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          SEQ_LEN = 4096;

    typedef enum int {EV_SPAWN = 0, EV_HIT = 1, EV_MISS = 2} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       idx;
        int       at_edge;
    } exp_ev_t;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        whacked_i;
    logic [15:0] mole_o;
    logic [3:0]  mole_idx_o;
    logic        spawn_o;
    logic        hit_o;
    logic        miss_o;

    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          exp_prev = 0;
    int          last_spawn = 0;
    logic [15:0] seq [SEQ_LEN];
    exp_ev_t     q [$];

    mole_spawner #(
        .UP_CYCLES  (UP_N),
        .GAP_CYCLES (GAP_N),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .whacked_i  (whacked_i),
        .mole_o     (mole_o),
        .mole_idx_o (mole_idx_o),
        .spawn_o    (spawn_o),
        .hit_o      (hit_o),
        .miss_o     (miss_o)
    );

    always #5 clk_i = ~clk_i;

    // Edge counter since reset release
    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t edge=%0d)", name, act, exp, $time, cyc - 1);
        end
    endtask

    function automatic logic [15:0] onehot(input int i);
        logic [15:0] v;
        logic [3:0]  b;
        b    = 4'(i);
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic push_spawn(input int k);
        logic [15:0] v;
        int          c;
        exp_ev_t     e;
        v = seq[k];
        c = int'(v[3:0]);
        if (c == exp_prev) c = (c + 1) % 16;
        e.kind = EV_SPAWN; e.idx = c; e.at_edge = k;
        q.push_back(e);
        exp_prev = c;
    endtask

    task automatic push_retire(input ev_kind_e kind, input int k);
        exp_ev_t e;
        e.kind = kind; e.idx = exp_prev; e.at_edge = k;
        q.push_back(e);
    endtask

    // Park on the falling edge that follows edge k
    task automatic wait_after(input int k);
        int guard;
        guard = 0;
        while (cyc < k + 1 && guard < 20000) begin
            @(negedge clk_i);
            guard++;
        end
        if (cyc < k + 1) check(1'b0, "wait_timeout", cyc, k + 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits an event pulse
    always @(negedge clk_i) begin : mon
        int       npulse;
        ev_kind_e got;
        exp_ev_t  e;
        if (reset_i) begin
            last_spawn = 0;
        end else begin
            if (mole_o != '0)
                check(mole_o == onehot(int'(mole_idx_o)), "mole_onehot", mole_o, onehot(int'(mole_idx_o)));
            npulse = int'(spawn_o) + int'(hit_o) + int'(miss_o);
            if (npulse != 0) begin
                check(npulse == 1, "pulse_exclusive", npulse, 1);
                got = spawn_o ? EV_SPAWN : (hit_o ? EV_HIT : EV_MISS);
                if (q.size() == 0) begin
                    check(1'b0, "unexpected_event", int'(got), 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check(got == e.kind, "event_kind", int'(got), int'(e.kind));
                    check(cyc - 1 == e.at_edge, "event_edge", cyc - 1, e.at_edge);
                    check(int'(mole_idx_o) == e.idx, "event_idx", mole_idx_o, e.idx);
                    if (got == EV_SPAWN) begin
                        check(mole_o == onehot(e.idx), "spawn_mole", mole_o, onehot(e.idx));
                        check(int'(mole_idx_o) != last_spawn, "no_repeat", mole_idx_o, last_spawn);
                        last_spawn = int'(mole_idx_o);
                    end else begin
                        check(mole_o == '0, "retire_mole", mole_o, 0);
                    end
                end
            end
        end
    end

    initial begin
        int s;
        seq[0] = SEED;
        for (int i = 1; i < SEQ_LEN; i++) seq[i] = (seq[i-1] >> 1) ^ (seq[i-1][0] ? 16'hB400 : 16'h0000);

        reset_i = 1'b1; enable_i = 1'b0; whacked_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check(mole_o == '0,     "rst_mole",  mole_o, 0);
        check(mole_idx_o == '0, "rst_idx",   mole_idx_o, 0);
        check(spawn_o == 1'b0,  "rst_spawn", spawn_o, 0);
        check(hit_o == 1'b0,    "rst_hit",   hit_o, 0);
        check(miss_o == 1'b0,   "rst_miss",  miss_o, 0);
        reset_i = 1'b0; enable_i = 1'b1;

        // 200 unwhacked moles: spawn every 12 edges, miss 8 edges after spawn
        for (int n = 0; n < 200; n++) begin
            push_spawn(4 + 12 * n);
            push_retire(EV_MISS, 4 + 12 * n + 8);
        end
        wait_after(3);
        check(mole_o == '0 && !spawn_o, "gap_quiet", mole_o, 0);
        wait_after(4);
        check(mole_idx_o == 4'd14, "first_idx", mole_idx_o, 14);
        check(mole_o == 16'h4000,  "first_mole", mole_o, 16'h4000);
        wait_after(2400);

        // Whack on the 3rd up cycle
        s = 2404;
        push_spawn(s);
        push_retire(EV_HIT, s + 3);
        wait_after(s + 2); whacked_i = 1'b1;
        wait_after(s + 3); whacked_i = 1'b0;

        // Whack on the final up cycle collides with the timeout
        s = s + 7;
        push_spawn(s);
        push_retire(EV_HIT, s + 8);
        wait_after(s + 7); whacked_i = 1'b1;
        wait_after(s + 8); whacked_i = 1'b0;

        // Disable on the 5th up cycle, with a simultaneous whack
        s = s + 12;
        push_spawn(s);
        wait_after(s + 4); enable_i = 1'b0; whacked_i = 1'b1;
        wait_after(s + 5);
        check(mole_o == '0, "disable_mole", mole_o, 0);
        check(int'(mole_idx_o) == exp_prev, "disable_idx_kept", mole_idx_o, exp_prev);
        check(!spawn_o && !hit_o && !miss_o, "disable_no_pulse", {spawn_o, hit_o, miss_o}, 0);
        // Re-enable with a stale whack held through idle and gap
        wait_after(s + 7); enable_i = 1'b1;
        s = s + 12;
        push_spawn(s);
        wait_after(s); whacked_i = 1'b0;

        // Asynchronous reset in the middle of an up phase
        wait_after(s + 2);
        check(mole_o != '0, "pre_reset_mole_up", mole_o, 1);
        #2 reset_i = 1'b1;
        #1;
        check(mole_o == '0,     "async_rst_mole", mole_o, 0);
        check(mole_idx_o == '0, "async_rst_idx",  mole_idx_o, 0);
        check(q.size() == 0,    "queue_before_reset", q.size(), 0);
        exp_prev = 0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;

        // Same index sequence as after the first reset
        for (int n = 0; n < 5; n++) begin
            push_spawn(4 + 12 * n);
            push_retire(EV_MISS, 4 + 12 * n + 8);
        end
        wait_after(4);
        check(mole_idx_o == 4'd14, "restart_first_idx", mole_idx_o, 14);
        wait_after(4 + 12 * 4 + 8 + 2);
        check(q.size() == 0, "queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
